// File: rtl/note_env_pkg.sv
// Shared state encoding, level limits and default tuning constants for the ADSR note envelope.
package note_env_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } env_state_e;

   localparam int LEVEL_MAX        = 255;
   localparam int DEF_TICK_DIV     = 12000;
   localparam int DEF_ATTACK_STEP  = 8;
   localparam int DEF_DECAY_STEP   = 2;
   localparam int DEF_SUSTAIN_LVL  = 160;
   localparam int DEF_RELEASE_STEP = 4;
   localparam int DEF_MID          = 64;

   // Clamp a signed intermediate sample to the 8-bit excess code the DAC accepts.
   function automatic logic [7:0] clip_u8(input logic signed [17:0] v);
      if (v < 0)
         return 8'h00;
      else if (v > 18'sd255)
         return 8'hFF;
      else
         return v[7:0];
   endfunction

endpackage

// File: rtl/env_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks, paces all envelope level changes.
module env_tick_gen #(
   parameter int TICK_DIV = 12000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // NOTE: every always_comb output gets a value before any branch, so no latch can be inferred.
   always_comb begin
      tick  = (cnt_q == CW'(TICK_DIV - 1));
      cnt_d = tick ? '0 : cnt_q + CW'(1);
   end

   // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/note_envelope.sv
// ADSR amplitude envelope driven by CPU note-code changes; scales the mixer sample about MID for the DAC.
// Build option: define NOTE_ENV_RETRIG_EN to re-attack on a change between two non-zero notes (default legato).
module note_envelope
   import note_env_pkg::*;
#(
   parameter int TICK_DIV     = DEF_TICK_DIV,
   parameter int ATTACK_STEP  = DEF_ATTACK_STEP,
   parameter int DECAY_STEP   = DEF_DECAY_STEP,
   parameter int SUSTAIN_LVL  = DEF_SUSTAIN_LVL,
   parameter int RELEASE_STEP = DEF_RELEASE_STEP,
   parameter int MID          = DEF_MID
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] f_note,
   input  logic [7:0] sample_in,
   output logic [7:0] sample_out,
   output logic [7:0] env_level,
   output logic [2:0] env_state,
   output logic       env_active
);

   logic       tick;
   logic [7:0] note_s1_q, note_s1_d;
   logic [7:0] note_s2_q, note_s2_d;
   logic [7:0] note_prev_q, note_prev_d;
   env_state_e state_q, state_d;
   logic [7:0] level_q, level_d;
   logic [7:0] sample_q, sample_d;

   logic note_on;
   logic note_off;
   logic rearm;
   int   lvl_up;
   int   lvl_dec;
   int   lvl_rel;

   logic signed [17:0] diff;
   logic signed [17:0] lvl_s;
   logic signed [17:0] prod;
   logic signed [17:0] scaled;

   env_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   // f_note is asynchronous to this domain; two stages plus a history register for edge detection.
   always_comb begin
      note_s1_d   = f_note;
      note_s2_d   = note_s1_q;
      note_prev_d = note_s2_q;
      note_on     = (note_s2_q != 8'h00) && (note_s2_q != note_prev_q);
      note_off    = (note_s2_q == 8'h00) && (note_prev_q != 8'h00);
`ifdef NOTE_ENV_RETRIG_EN
      rearm       = note_on;
`else
      rearm       = note_on && (note_prev_q == 8'h00);
`endif
   end

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      lvl_up  = int'(level_q) + ATTACK_STEP;
      lvl_dec = int'(level_q) - DECAY_STEP;
      lvl_rel = int'(level_q) - RELEASE_STEP;
      // A note event always beats a coincident tick: the state moves, the level holds.
      case (state_q)
         ST_IDLE: begin
            level_d = '0;
            if (note_on) state_d = ST_ATTACK;
         end
         ST_ATTACK: begin
            if (note_off) begin
               state_d = ST_RELEASE;
            end else if (!rearm && tick) begin
               if (lvl_up >= LEVEL_MAX) begin
                  level_d = 8'(LEVEL_MAX);
                  state_d = ST_DECAY;
               end else begin
                  level_d = 8'(lvl_up);
               end
            end
         end
         ST_DECAY: begin
            if (note_off) begin
               state_d = ST_RELEASE;
            end else if (rearm) begin
               state_d = ST_ATTACK;
            end else if (tick) begin
               if (lvl_dec <= SUSTAIN_LVL) begin
                  level_d = 8'(SUSTAIN_LVL);
                  state_d = ST_SUSTAIN;
               end else begin
                  level_d = 8'(lvl_dec);
               end
            end
         end
         ST_SUSTAIN: begin
            if (note_off)   state_d = ST_RELEASE;
            else if (rearm) state_d = ST_ATTACK;
         end
         ST_RELEASE: begin
            if (note_on) begin
               state_d = ST_ATTACK;
            end else if (tick) begin
               if (lvl_rel <= 0) begin
                  level_d = '0;
                  state_d = ST_IDLE;
               end else begin
                  level_d = 8'(lvl_rel);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            level_d = '0;
         end
      endcase
   end

   always_comb begin
      diff     = $signed({10'b0, sample_in}) - $signed(18'(MID));
      lvl_s    = $signed({10'b0, level_q});
      prod     = diff * lvl_s;
      scaled   = $signed(18'(MID)) + (prod >>> 8);
      sample_d = clip_u8(scaled);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         note_s1_q   <= '0;
         note_s2_q   <= '0;
         note_prev_q <= '0;
         state_q     <= ST_IDLE;
         level_q     <= '0;
         sample_q    <= 8'(MID);
      end else begin
         note_s1_q   <= note_s1_d;
         note_s2_q   <= note_s2_d;
         note_prev_q <= note_prev_d;
         state_q     <= state_d;
         level_q     <= level_d;
         sample_q    <= sample_d;
      end
   end

   assign sample_out = sample_q;
   assign env_level  = level_q;
   assign env_state  = state_q;
   assign env_active = (state_q != ST_IDLE);

endmodule

// File: tb/tb_note_envelope.sv
// Directed scoreboard bench for note_envelope (TICK_DIV=4): stimulus queues expected outputs, a negedge monitor compares.
module tb_note_envelope;
   import note_env_pkg::*;

   logic       clk;
   logic       reset;
   logic [7:0] f_note;
   logic [7:0] sample_in;
   logic [7:0] sample_out;
   logic [7:0] env_level;
   logic [2:0] env_state;
   logic       env_active;

   note_envelope #(
      .TICK_DIV (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .f_note     (f_note),
      .sample_in  (sample_in),
      .sample_out (sample_out),
      .env_level  (env_level),
      .env_state  (env_state),
      .env_active (env_active)
   );

   typedef struct {
      string      name;
      int         due;
      logic [2:0] st;
      logic [7:0] lvl;
      bit         chk_s;
      logic [7:0] smp;
   } exp_t;

   exp_t q[$];
   int   neg_cnt = 0;
   int   n_total = 0;
   int   n_pass  = 0;
   int   ecnt    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input bit ok);
      n_total++;
      if (ok)
         n_pass++;
      else
         $display("FAIL %s: got state=%0d level=%0d sample=%0d active=%0b",
                  name, env_state, env_level, sample_out, env_active);
   endtask

   always @(negedge clk) begin
      neg_cnt++;
      while (q.size() > 0 && q[0].due <= neg_cnt) begin
         exp_t e;
         bit   ok;
         e  = q.pop_front();
         ok = (e.due == neg_cnt) && (env_state === e.st) && (env_level === e.lvl) &&
              (env_active === (e.st != 3'd0)) && (!e.chk_s || (sample_out === e.smp));
         if (!ok)
            $display("  want state=%0d level=%0d sample=%0d(chk=%0b) active=%0b",
                     e.st, e.lvl, e.smp, e.chk_s, (e.st != 3'd0));
         check(e.name, ok);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One clock edge; tracks edges since reset so the bench knows independently when ticks fall.
   task automatic step(output bit t);
      @(posedge clk);
      if (reset) begin
         ecnt = 0;
         t    = 1'b0;
      end else begin
         ecnt++;
         t = (ecnt % 4 == 0);
      end
      #1;
   endtask

   task automatic wait_ticks(input int n);
      int got = 0;
      bit t;
      while (got < n) begin
         step(t);
         if (t) got++;
      end
   endtask

   // Change the note so its event edge (third edge) is or is not a tick edge; reports ticks seen before it.
   task automatic change_note(input logic [7:0] code, input bit on_tick, output int ticks_before);
      bit t;
      int target = on_tick ? 1 : 2;
      ticks_before = 0;
      while (ecnt % 4 != target) begin
         step(t);
         if (t) ticks_before++;
      end
      f_note = code;
      for (int i = 0; i < 2; i++) begin
         step(t);
         if (t) ticks_before++;
      end
      step(t);
   endtask

   task automatic expect_out(input string name, input logic [2:0] st, input int lvl,
                             input bit chk_s, input int smp);
      exp_t e;
      e.name  = name;
      e.due   = neg_cnt + 1;
      e.st    = st;
      e.lvl   = lvl[7:0];
      e.chk_s = chk_s;
      e.smp   = smp[7:0];
      q.push_back(e);
   endtask

   initial begin
      bit t;
      int k;
      int lvl;

      reset     = 1'b1;
      f_note    = 8'h00;
      sample_in = 8'd127;
      for (int i = 0; i < 3; i++) step(t);
      check("reset_direct_state", env_state === ST_IDLE);
      check("reset_direct_level", env_level === 8'd0);
      check("reset_direct_sample", sample_out === 8'd64);
      check("reset_direct_active", env_active === 1'b0);
      expect_out("reset_state", ST_IDLE, 0, 1'b1, 64);
      reset = 1'b0;

      // Attack ramp, clip at full scale, decay to sustain.
      change_note(8'hA0, 1'b0, k);
      expect_out("attack_entry", ST_ATTACK, 0, 1'b1, 64);
      wait_ticks(1);
      expect_out("attack_first_tick", ST_ATTACK, 8, 1'b0, 0);
      step(t);
      expect_out("attack_sample_lvl8", ST_ATTACK, 8, 1'b1, 65);
      wait_ticks(30);
      expect_out("attack_248", ST_ATTACK, 248, 1'b0, 0);
      wait_ticks(1);
      expect_out("attack_sat_to_decay", ST_DECAY, 255, 1'b0, 0);
      sample_in = 8'd0;
      step(t);
      expect_out("clip_low", ST_DECAY, 255, 1'b1, 0);
      sample_in = 8'd127;
      step(t);
      expect_out("full_scale_sample", ST_DECAY, 255, 1'b1, 126);
      wait_ticks(47);
      expect_out("decay_161", ST_DECAY, 161, 1'b0, 0);
      wait_ticks(1);
      expect_out("decay_floor_sustain", ST_SUSTAIN, 160, 1'b0, 0);
      step(t);
      step(t);
      expect_out("sustain_sample", ST_SUSTAIN, 160, 1'b1, 103);
      wait_ticks(3);
      expect_out("sustain_hold", ST_SUSTAIN, 160, 1'b1, 103);

      // Note change between two non-zero codes.
      change_note(8'h80, 1'b0, k);
`ifdef NOTE_ENV_RETRIG_EN
      expect_out("retrig_attack", ST_ATTACK, 160, 1'b1, 103);
      wait_ticks(1);
      expect_out("retrig_168", ST_ATTACK, 168, 1'b0, 0);
      wait_ticks(11);
      expect_out("retrig_sat", ST_DECAY, 255, 1'b0, 0);
      wait_ticks(48);
      expect_out("retrig_sustain", ST_SUSTAIN, 160, 1'b0, 0);
`else
      expect_out("legato_ignore", ST_SUSTAIN, 160, 1'b1, 103);
      wait_ticks(2);
      expect_out("legato_hold", ST_SUSTAIN, 160, 1'b1, 103);
`endif

      // Release to silence.
      change_note(8'h00, 1'b0, k);
      expect_out("release_entry", ST_RELEASE, 160, 1'b1, 103);
      wait_ticks(1);
      expect_out("release_156", ST_RELEASE, 156, 1'b0, 0);
      wait_ticks(38);
      expect_out("release_4", ST_RELEASE, 4, 1'b0, 0);
      wait_ticks(1);
      expect_out("release_to_idle", ST_IDLE, 0, 1'b1, 64);
      step(t);
      expect_out("idle_silence", ST_IDLE, 0, 1'b1, 64);

      // Note-off mid attack, then note-on landing on a tick edge in RELEASE.
      change_note(8'hA0, 1'b0, k);
      expect_out("attack2_entry", ST_ATTACK, 0, 1'b1, 64);
      wait_ticks(4);
      expect_out("attack2_32", ST_ATTACK, 32, 1'b0, 0);
      change_note(8'h00, 1'b0, k);
      lvl = 32 + 8 * k;
      expect_out("off_in_attack", ST_RELEASE, lvl, 1'b0, 0);
      change_note(8'hA0, 1'b1, k);
      lvl = lvl - 4 * k;
      expect_out("on_with_tick_holds", ST_ATTACK, lvl, 1'b0, 0);
      wait_ticks(1);
      expect_out("reattack_from_level", ST_ATTACK, lvl + 8, 1'b0, 0);

      // Reset aborts immediately, no ramp.
      reset  = 1'b1;
      f_note = 8'h00;
      step(t);
      expect_out("reset_abort1", ST_IDLE, 0, 1'b1, 64);
      reset = 1'b0;
      change_note(8'hA0, 1'b0, k);
      expect_out("attack3_entry", ST_ATTACK, 0, 1'b1, 64);
      wait_ticks(12);
      expect_out("attack3_96", ST_ATTACK, 96, 1'b0, 0);
      reset  = 1'b1;
      f_note = 8'h00;
      step(t);
      expect_out("reset_at_96", ST_IDLE, 0, 1'b1, 64);
      reset = 1'b0;
      step(t);
      step(t);
      expect_out("idle_after_reset", ST_IDLE, 0, 1'b1, 64);

      step(t);
      step(t);
      check("final_direct_state", env_state === ST_IDLE);
      check("final_direct_level", env_level === 8'd0);
      check("final_direct_sample", sample_out === 8'd64);
      check("final_direct_active", env_active === 1'b0);
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         n_total++;
         $display("FAIL %s: expectation never compared (due %0d, now %0d)", e.name, e.due, neg_cnt);
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
